// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: state encoding, opcodes
// shared with the control unit, and the per-state output decode.
package interrupt_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_SAFE = 3'd1;
  localparam state_t ST_FLUSH     = 3'd2;
  localparam state_t ST_INJECT    = 3'd3;
  localparam state_t ST_SERVICE   = 3'd4;

  localparam logic [4:0] OP_CALL = 5'b00101;
  localparam logic [4:0] OP_RTI  = 5'b00011;

  typedef struct packed {
    logic       inject;
    logic [4:0] op_code;
    logic       interrupt;
    logic       flush_fetch;
    logic       hold_pc;
    logic       in_service;
  } seq_out_t;

  // Pure state decode keeps every sequencer output Moore-style.
  function automatic seq_out_t decode_state(input state_t state, input logic [4:0] call_op);
    seq_out_t o;
    o = '0;
    case (state)
      ST_FLUSH: begin
        o.flush_fetch = 1'b1;
        o.hold_pc     = 1'b1;
      end
      ST_INJECT: begin
        o.inject    = 1'b1;
        o.op_code   = call_op;
        o.interrupt = 1'b1;
        o.hold_pc   = 1'b1;
      end
      ST_SERVICE: o.in_service = 1'b1;
      default:    o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/interrupt_sequencer_sync_edge_detect.sv
// Multi-stage synchroniser for the asynchronous interrupt pin followed by a
// rising-edge detector on the synchronised level.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_rise = sync_q[SYNC_STAGES-1] & ~s_d;

endmodule

// File: rtl/interrupt_sequencer.sv
// Steers an external interrupt into the pipeline: waits for a safe boundary,
// flushes fetch, injects a qualified CALL and blocks re-entry until RTI retires.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [4:0] CALL_OPCODE = OP_CALL
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_interrupt,
  input  logic       i_stall,
  input  logic       i_branch_pending,
  input  logic       i_rti_retire,
  output logic       o_inject,
  output logic [4:0] o_op_code,
  output logic       o_interrupt,
  output logic       o_flush_fetch,
  output logic       o_hold_pc,
  output logic       o_in_service,
  output logic       o_missed
);

  state_t   state_q;
  state_t   state_d;
  logic     rise;
  logic     pending_q;
  logic     missed_q;
  logic     leave_inject;
  seq_out_t dec;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_async(i_interrupt),
    .o_rise (rise)
  );

  assign leave_inject = (state_q == ST_INJECT) && !i_stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (pending_q || rise) state_d = ST_WAIT_SAFE;
      ST_WAIT_SAFE: if (!i_stall && !i_branch_pending) state_d = ST_FLUSH;
      ST_FLUSH:     state_d = ST_INJECT;
      ST_INJECT:    if (!i_stall) state_d = ST_SERVICE;
      ST_SERVICE:   if (i_rti_retire) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // An edge coinciding with the CALL leaving INJECT is the next request, not a drop.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      missed_q <= rise && pending_q && !leave_inject;
      if (leave_inject) begin
        pending_q <= rise;
      end else if (rise) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    dec           = decode_state(state_q, CALL_OPCODE);
    o_inject      = dec.inject;
    o_op_code     = dec.op_code;
    o_interrupt   = dec.interrupt;
    o_flush_fetch = dec.flush_fetch;
    o_hold_pc     = dec.hold_pc;
    o_in_service  = dec.in_service;
    o_missed      = missed_q;
  end

endmodule
